// File: rtl/ctrl_sequencer_pkg.sv
// Shared definitions for the control sequencer: state encodings, ISA opcodes
// and the one-hot opcode-class vector consumed by the sequencer and field decode.
package ctrl_sequencer_pkg;

  localparam logic [2:0] CTRL_ST_FETCH  = 3'd0;
  localparam logic [2:0] CTRL_ST_DECODE = 3'd1;
  localparam logic [2:0] CTRL_ST_EXEC   = 3'd2;
  localparam logic [2:0] CTRL_ST_MEM    = 3'd3;
  localparam logic [2:0] CTRL_ST_WB     = 3'd4;
  localparam logic [2:0] CTRL_ST_HALT   = 3'd5;

  localparam logic [4:0] ISA_NOP  = 5'd0;
  localparam logic [4:0] ISA_ADD  = 5'd1;
  localparam logic [4:0] ISA_SUB  = 5'd2;
  localparam logic [4:0] ISA_AND  = 5'd3;
  localparam logic [4:0] ISA_OR   = 5'd4;
  localparam logic [4:0] ISA_XOR  = 5'd5;
  localparam logic [4:0] ISA_SLL  = 5'd6;
  localparam logic [4:0] ISA_SRL  = 5'd7;
  localparam logic [4:0] ISA_ADDI = 5'd8;
  localparam logic [4:0] ISA_ANDI = 5'd9;
  localparam logic [4:0] ISA_ORI  = 5'd10;
  localparam logic [4:0] ISA_MFH  = 5'd11;
  localparam logic [4:0] ISA_MFL  = 5'd12;
  localparam logic [4:0] ISA_MUL  = 5'd13;
  localparam logic [4:0] ISA_DIV  = 5'd14;
  localparam logic [4:0] ISA_LD   = 5'd15;
  localparam logic [4:0] ISA_LI   = 5'd16;
  localparam logic [4:0] ISA_ST   = 5'd17;
  localparam logic [4:0] ISA_BEQ  = 5'd18;
  localparam logic [4:0] ISA_BNE  = 5'd19;
  localparam logic [4:0] ISA_BLT  = 5'd20;
  localparam logic [4:0] ISA_JFR  = 5'd21;
  localparam logic [4:0] ISA_JAL  = 5'd22;
  localparam logic [4:0] ISA_HLT  = 5'd31;

  // Exactly one member is set for any opcode; unassigned opcodes decode as nop.
  typedef struct packed {
    logic ldi;
    logic st;
    logic br;
    logic jfr;
    logic jal;
    logic muldiv;
    logic hlt;
    logic nop;
    logic alu;
  } op_class_t;

  function automatic logic is_mem_class(input op_class_t c);
    return c.ldi | c.st;
  endfunction

endpackage

// File: rtl/ctrl_sequencer_op_class.sv
// Combinational opcode-class decode (module ctrl_op_class), shared between the
// sequencer and the field-level decode; takes the opcode field of the IR.
module ctrl_op_class
  import ctrl_sequencer_pkg::*;
(
  input  logic [4:0] i_opc,
  output op_class_t  o_cls
);

  always_comb begin
    o_cls = '0;
    case (i_opc)
      ISA_LD, ISA_LI:                  o_cls.ldi    = 1'b1;
      ISA_ST:                          o_cls.st     = 1'b1;
      ISA_BEQ, ISA_BNE, ISA_BLT:       o_cls.br     = 1'b1;
      ISA_JFR:                         o_cls.jfr    = 1'b1;
      ISA_JAL:                         o_cls.jal    = 1'b1;
      ISA_MUL, ISA_DIV:                o_cls.muldiv = 1'b1;
      ISA_HLT:                         o_cls.hlt    = 1'b1;
      ISA_ADD, ISA_SUB, ISA_AND, ISA_OR, ISA_XOR, ISA_SLL, ISA_SRL,
      ISA_ADDI, ISA_ANDI, ISA_ORI, ISA_MFH, ISA_MFL:
                                       o_cls.alu    = 1'b1;
      default:                         o_cls.nop    = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: fetches into a local IR and walks FETCH/DECODE/EXEC/MEM/WB/HALT
// per opcode class. Define CTRL_SEQ_PERF_EN to add the oRetired/oCycles performance counters.
module ctrl_sequencer
  import ctrl_sequencer_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int OPC_MSB     = 31,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              iClk,
  input  logic              nRst,
  input  logic              iRdy,
  input  logic [DATA_W-1:0] iMemData,
  input  logic              iMemAck,
  input  logic              iALU_Done,
  input  logic              iCond,
  input  logic              iResume,
  output logic [DATA_W-1:0] oIR,
  output logic [2:0]        oState,
  output logic              oMemRead,
  output logic              oMemWrite,
  output logic              oRMA_en,
  output logic              oIR_en,
  output logic              oPC_en,
  output logic              oPC_jmp,
  output logic              oPC_loadRA,
  output logic              oALU_Start,
  output logic              oRF_Write,
  output logic              oRAS_en,
  output logic              oHalted,
`ifdef CTRL_SEQ_PERF_EN
  output logic [DATA_W-1:0] oRetired,
  output logic [DATA_W-1:0] oCycles,
`endif
  output logic              oFault
);

  localparam logic [31:0] TIMEOUT_LIM = MEM_TIMEOUT;
  localparam bit          TIMEOUT_EN  = (MEM_TIMEOUT != 0);

  logic [2:0]        r_state;
  logic [2:0]        w_state_next;
  logic [DATA_W-1:0] r_ir;
  logic [31:0]       r_wait;
  logic [31:0]       w_wait_inc;
  logic              r_fault;
  logic              r_alu_pend;
  op_class_t         w_cls;

  logic w_fetch, w_decode, w_exec, w_mem, w_wb, w_halt;
  logic w_req, w_ack, w_waiting, w_timeout;

  ctrl_op_class u_op_class (
    .i_opc (r_ir[OPC_MSB -: 5]),
    .o_cls (w_cls)
  );

  assign w_fetch  = (r_state == CTRL_ST_FETCH);
  assign w_decode = (r_state == CTRL_ST_DECODE);
  assign w_exec   = (r_state == CTRL_ST_EXEC);
  assign w_mem    = (r_state == CTRL_ST_MEM);
  assign w_wb     = (r_state == CTRL_ST_WB);
  assign w_halt   = (r_state == CTRL_ST_HALT);

  // Acks only count while a request is actually on the bus.
  assign w_req      = w_fetch | (w_mem & is_mem_class(w_cls));
  assign w_ack      = w_req & iMemAck;
  assign w_waiting  = w_req & ~iMemAck;
  assign w_wait_inc = r_wait + 32'd1;
  assign w_timeout  = TIMEOUT_EN && w_waiting && (w_wait_inc == TIMEOUT_LIM);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CTRL_ST_FETCH:  if (w_ack) w_state_next = CTRL_ST_DECODE;
      CTRL_ST_DECODE: begin
        if (w_cls.hlt)      w_state_next = CTRL_ST_HALT;
        else if (w_cls.nop) w_state_next = CTRL_ST_FETCH;
        else                w_state_next = CTRL_ST_EXEC;
      end
      CTRL_ST_EXEC: begin
        if (w_cls.muldiv) begin
          if (iALU_Done) w_state_next = CTRL_ST_FETCH;
        end
        else if (w_cls.br | w_cls.jfr)           w_state_next = CTRL_ST_FETCH;
        else if (is_mem_class(w_cls))            w_state_next = CTRL_ST_MEM;
        else if (w_cls.jal | w_cls.alu)          w_state_next = CTRL_ST_WB;
        else                                     w_state_next = CTRL_ST_FETCH;
      end
      CTRL_ST_MEM: begin
        if (w_ack) w_state_next = w_cls.st ? CTRL_ST_FETCH : CTRL_ST_WB;
      end
      CTRL_ST_WB:     w_state_next = CTRL_ST_FETCH;
      CTRL_ST_HALT:   if (iResume) w_state_next = CTRL_ST_FETCH;
      default:        w_state_next = CTRL_ST_FETCH;
    endcase
    if (w_timeout) w_state_next = CTRL_ST_HALT;
  end

  always_ff @(posedge iClk) begin
    if (!nRst) begin
      r_state    <= CTRL_ST_FETCH;
      r_ir       <= '0;
      r_wait     <= '0;
      r_fault    <= 1'b0;
      r_alu_pend <= 1'b0;
    end
    else if (iRdy) begin
      r_state <= w_state_next;
      if (w_fetch && w_ack) r_ir <= iMemData;
      if (w_state_next != r_state) r_wait <= '0;
      else if (w_waiting)          r_wait <= w_wait_inc;
      if (w_timeout) r_fault <= 1'b1;
      // Armed on EXEC entry, consumed by the first EXEC cycle that actually steps.
      r_alu_pend <= (w_state_next == CTRL_ST_EXEC) && !w_exec;
    end
  end

  assign oIR        = r_ir;
  assign oState     = r_state;
  assign oMemRead   = w_fetch | (w_mem & w_cls.ldi);
  assign oMemWrite  = w_mem & w_cls.st;
  assign oRMA_en    = w_fetch | w_mem;
  assign oIR_en     = iRdy & w_fetch & w_ack;
  assign oPC_en     = iRdy & ((w_fetch & w_ack) |
                              (w_exec & ((w_cls.br & iCond) | w_cls.jfr | w_cls.jal)));
  assign oPC_jmp    = iRdy & w_exec & w_cls.br & iCond;
  assign oPC_loadRA = iRdy & w_exec & (w_cls.jfr | w_cls.jal);
  assign oALU_Start = iRdy & w_exec & r_alu_pend;
  assign oRF_Write  = iRdy & w_wb;
  assign oRAS_en    = iRdy & w_exec & w_cls.muldiv & iALU_Done;
  assign oHalted    = w_halt;
  assign oFault     = r_fault;

`ifdef CTRL_SEQ_PERF_EN
  localparam logic [DATA_W-1:0] PERF_ONE = 1;

  logic [DATA_W-1:0] r_retired;
  logic [DATA_W-1:0] r_cycles;
  logic              w_retire;

  assign w_retire = (w_state_next == CTRL_ST_FETCH) & (w_decode | w_exec | w_mem | w_wb);

  always_ff @(posedge iClk) begin
    if (!nRst) begin
      r_retired <= '0;
      r_cycles  <= '0;
    end
    else if (iRdy) begin
      if (!w_halt)  r_cycles  <= r_cycles + PERF_ONE;
      if (w_retire) r_retired <= r_retired + PERF_ONE;
    end
  end

  assign oRetired = r_retired;
  assign oCycles  = r_cycles;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: each instruction is expanded into an expected
// per-cycle trace (inputs + outputs) from the opcode class rules, then replayed and compared.
module tb_ctrl_sequencer;
  import ctrl_sequencer_pkg::*;

  localparam int TMO = 4;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  // Observed output vector bit masks.
  localparam logic [11:0] MRD  = 12'h800, MWR = 12'h400, RMA = 12'h200, IREN = 12'h100;
  localparam logic [11:0] PCEN = 12'h080, JMP = 12'h040, LRA = 12'h020, ALUS = 12'h010;
  localparam logic [11:0] RFW  = 12'h008, RAS = 12'h004, HLTD = 12'h002, FLT = 12'h001;
  localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3, SW = 3'd4, SH = 3'd5;
  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_JFR = 4, K_JAL = 5,
                 K_MD = 6, K_HLT = 7, K_NOP = 8;

  logic        clk = 1'b0;
  logic        nRst = 1'b0, iRdy = 1'b0, iMemAck = 1'b0, iALU_Done = 1'b0;
  logic        iCond = 1'b0, iResume = 1'b0;
  logic [31:0] iMemData = '0;
  logic [31:0] oIR;
  logic [2:0]  oState;
  logic oMemRead, oMemWrite, oRMA_en, oIR_en, oPC_en, oPC_jmp, oPC_loadRA;
  logic oALU_Start, oRF_Write, oRAS_en, oHalted, oFault;
`ifdef CTRL_SEQ_PERF_EN
  logic [31:0] oRetired, oCycles;
`endif

  always #5 clk = ~clk;

  ctrl_sequencer #(.DATA_W(32), .OPC_MSB(31), .MEM_TIMEOUT(TMO)) dut (
    .iClk(clk), .nRst(nRst), .iRdy(iRdy), .iMemData(iMemData), .iMemAck(iMemAck),
    .iALU_Done(iALU_Done), .iCond(iCond), .iResume(iResume), .oIR(oIR), .oState(oState),
    .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oRMA_en(oRMA_en), .oIR_en(oIR_en),
    .oPC_en(oPC_en), .oPC_jmp(oPC_jmp), .oPC_loadRA(oPC_loadRA), .oALU_Start(oALU_Start),
    .oRF_Write(oRF_Write), .oRAS_en(oRAS_en), .oHalted(oHalted),
`ifdef CTRL_SEQ_PERF_EN
    .oRetired(oRetired), .oCycles(oCycles),
`endif
    .oFault(oFault)
  );

  logic [11:0] w_obs;
  assign w_obs = {oMemRead, oMemWrite, oRMA_en, oIR_en, oPC_en, oPC_jmp, oPC_loadRA,
                  oALU_Start, oRF_Write, oRAS_en, oHalted, oFault};

  typedef struct {
    logic        rstn, rdy, ack, done, cond, res;
    logic [31:0] data;
    logic [2:0]  st;
    logic [11:0] o;
    logic [31:0] ir;
  } cyc_t;

  cyc_t        q[$];
  logic [31:0] m_ir = '0;
  logic        m_fault = 1'b0;
  int          stall_pct = 0;
  int          ncmp = 0, nerr = 0, cyc = 0, ninstr = 0;

  function automatic logic rb();
    return ($urandom_range(0, 1) != 0);
  endfunction

  function automatic int kind_of(input logic [4:0] o);
    case (o)
      ISA_LD, ISA_LI:             return K_LD;
      ISA_ST:                     return K_ST;
      ISA_BEQ, ISA_BNE, ISA_BLT:  return K_BR;
      ISA_JFR:                    return K_JFR;
      ISA_JAL:                    return K_JAL;
      ISA_MUL, ISA_DIV:           return K_MD;
      ISA_HLT:                    return K_HLT;
      ISA_ADD, ISA_SUB, ISA_AND, ISA_OR, ISA_XOR, ISA_SLL, ISA_SRL,
      ISA_ADDI, ISA_ANDI, ISA_ORI, ISA_MFH, ISA_MFL: return K_ALU;
      default:                    return K_NOP;
    endcase
  endfunction

  task automatic push(input logic [2:0] st, input logic [11:0] o, input logic rdy,
                      input logic ack, input logic done, input logic cond, input logic res,
                      input logic rstn, input logic [31:0] data);
    cyc_t c;
    c.st = st; c.o = o | (m_fault ? FLT : 12'h0); c.ir = m_ir;
    c.rdy = rdy; c.ack = ack; c.done = done; c.cond = cond; c.res = res;
    c.rstn = rstn; c.data = data;
    q.push_back(c);
  endtask

  // Optional iRdy=0 cycle: nothing moves, only request/halt levels remain visible.
  task automatic stall(input logic [2:0] st, input logic [11:0] lv);
    if ($urandom_range(0, 99) < stall_pct)
      push(st, lv, L, rb(), rb(), rb(), rb(), H, $urandom());
  endtask

  task automatic do_fetch(input int waits, input logic [31:0] data);
    for (int i = 0; i < waits; i++) begin
      stall(SF, MRD | RMA);
      push(SF, MRD | RMA, H, L, rb(), rb(), rb(), H, $urandom());
    end
    stall(SF, MRD | RMA);
    push(SF, MRD | RMA | IREN | PCEN, H, H, rb(), rb(), rb(), H, data);
    m_ir = data;
  endtask

  task automatic do_fetch_timeout();
    for (int i = 0; i < TMO; i++) begin
      stall(SF, MRD | RMA);
      push(SF, MRD | RMA, H, L, rb(), rb(), rb(), H, $urandom());
    end
    m_fault = 1'b1;
  endtask

  task automatic do_halt(input int idle, input bit rst_mid);
    for (int i = 0; i < idle; i++) begin
      stall(SH, HLTD);
      push(SH, HLTD, H, rb(), rb(), rb(), L, H, $urandom());
    end
    if (rst_mid) begin
      push(SH, HLTD, H, rb(), rb(), rb(), L, L, $urandom());
      m_ir = '0; m_fault = 1'b0;
    end
    else begin
      stall(SH, HLTD);
      push(SH, HLTD, H, rb(), rb(), rb(), H, H, $urandom());
    end
  endtask

  task automatic do_instr(input logic [4:0] opc, input int fw, input int mw, input int ad,
                          input logic cond, input int hidle, input bit rst_halt,
                          input bit rst_mem);
    logic [31:0] d;
    logic [11:0] lv;
    int          k;
    d = $urandom();
    d[31:27] = opc;
    k = kind_of(opc);
    do_fetch(fw, d);
    stall(SD, 12'h0);
    push(SD, 12'h0, H, rb(), rb(), rb(), rb(), H, $urandom());
    if (k == K_HLT) begin do_halt(hidle, rst_halt); return; end
    if (k == K_NOP) return;
    if (k == K_MD) begin
      for (int i = 0; i <= ad; i++) begin
        stall(SE, 12'h0);
        push(SE, ((i == 0) ? ALUS : 12'h0) | ((i == ad) ? RAS : 12'h0), H, rb(), (i == ad),
             rb(), rb(), H, $urandom());
      end
      return;
    end
    stall(SE, 12'h0);
    case (k)
      K_BR:         push(SE, ALUS | (cond ? (PCEN | JMP) : 12'h0), H, rb(), rb(), cond, rb(), H, $urandom());
      K_JFR, K_JAL: push(SE, ALUS | PCEN | LRA, H, rb(), rb(), rb(), rb(), H, $urandom());
      default:      push(SE, ALUS, H, rb(), rb(), rb(), rb(), H, $urandom());
    endcase
    if (k == K_BR || k == K_JFR) return;
    if (k == K_LD || k == K_ST) begin
      lv = (k == K_ST) ? (MWR | RMA) : (MRD | RMA);
      for (int i = 0; i < ((mw >= TMO) ? TMO : mw); i++) begin
        stall(SM, lv);
        push(SM, lv, H, L, rb(), rb(), rb(), H, $urandom());
      end
      if (mw >= TMO) begin m_fault = 1'b1; do_halt(hidle, 1'b0); return; end
      if (rst_mem) begin
        push(SM, lv, H, H, rb(), rb(), L, L, $urandom());
        m_ir = '0; m_fault = 1'b0;
        return;
      end
      stall(SM, lv);
      push(SM, lv, H, H, rb(), rb(), rb(), H, $urandom());
      if (k == K_ST) return;
    end
    stall(SW, 12'h0);
    push(SW, RFW, H, rb(), rb(), rb(), rb(), H, $urandom());
  endtask

  task automatic play(input string tag);
    cyc_t c;
    int   n;
    n = q.size();
    while (q.size() > 0) begin
      c = q.pop_front();
      @(posedge clk); #1;
      nRst = c.rstn; iRdy = c.rdy; iMemAck = c.ack; iALU_Done = c.done;
      iCond = c.cond; iResume = c.res; iMemData = c.data;
      @(negedge clk);
      ncmp++;
      assert (oState === c.st) else begin
        nerr++; $error("FAIL state cyc=%0d %s got=%0d exp=%0d", cyc, tag, oState, c.st);
      end
      ncmp++;
      assert (w_obs === c.o) else begin
        nerr++; $error("FAIL strobes cyc=%0d %s got=%b exp=%b", cyc, tag, w_obs, c.o);
      end
      ncmp++;
      assert (oIR === c.ir) else begin
        nerr++; $error("FAIL ir cyc=%0d %s got=%h exp=%h", cyc, tag, oIR, c.ir);
      end
      cyc++;
    end
    $display("txn %0d %s cycles=%0d", ninstr, tag, n);
    ninstr++;
  endtask

  task automatic run(input string tag, input logic [4:0] opc, input int fw, input int mw,
                     input int ad, input logic cond, input int hidle, input bit rst_halt,
                     input bit rst_mem);
    do_instr(opc, fw, mw, ad, cond, hidle, rst_halt, rst_mem);
    play(tag);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    stall_pct = 0;
    run("add_zero_wait", ISA_ADD, 0, 0, 0, L, 0, 0, 0);
    run("ld_mem_wait3",  ISA_LD,  0, 3, 0, L, 0, 0, 0);
    run("beq_cond0",     ISA_BEQ, 1, 0, 0, L, 0, 0, 0);
    run("beq_cond1",     ISA_BEQ, 0, 0, 0, H, 0, 0, 0);
    run("mul_done6",     ISA_MUL, 0, 0, 5, L, 0, 0, 0);
    run("jal_link",      ISA_JAL, 2, 0, 0, L, 0, 0, 0);
    do_fetch_timeout();
    do_halt(2, 1'b0);
    play("fetch_timeout");
    run("st_after_fault", ISA_ST, 0, 1, 0, L, 0, 0, 0);
    run("hlt_rst_mid",   ISA_HLT, 0, 0, 0, L, 2, 1, 0);
    run("unknown_op",    5'd25,   0, 0, 0, L, 0, 0, 0);
    stall_pct = 100;
    run("add_rdy_low",   ISA_ADD, 1, 0, 0, L, 0, 0, 0);
    run("st_rst_mem",    ISA_ST,  0, 1, 0, L, 0, 0, 1);
    run("mem_timeout",   ISA_LI,  0, TMO, 0, L, 1, 0, 0);
    stall_pct = 25;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        do_fetch_timeout();
        do_halt($urandom_range(0, 2), ($urandom_range(0, 1) != 0));
      end
      run("random", 5'($urandom_range(0, 31)), $urandom_range(0, 3),
          ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, 3), $urandom_range(0, 4),
          rb(), $urandom_range(0, 2), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
